// File: rtl/general_defs_pkg.sv
// Shared fetch definitions (GENERAL_DEFS): widths, fetch states, reset vector
// and program-memory depth used by the fetch unit and its next-PC selector.
package general_defs_pkg;

  localparam int WORD           = 32;
  localparam int HALF_WORD      = 16;
  localparam int PROG_MEM_DEPTH = 512;
  localparam int LOAD_ADDR_W    = $clog2(PROG_MEM_DEPTH);

  localparam logic [WORD-1:0] RESET_VECTOR = '0;

  typedef logic stall_pipeline_sig;

  typedef enum logic {
    FETCH_LOAD,
    FETCH_RUN
  } fetch_state_t;

  // Next program-load address, wrapping at the end of instruction memory
  // even if the depth is not a power of two.
  function automatic logic [LOAD_ADDR_W-1:0] load_addr_inc(input logic [LOAD_ADDR_W-1:0] addr);
    if (addr == LOAD_ADDR_W'(PROG_MEM_DEPTH - 1)) begin
      return '0;
    end
    return addr + LOAD_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection for the fetch unit: a taken branch wins over a stall,
// a stall holds the PC, otherwise the PC advances by one half-word.
module fetch_next_pc
  import general_defs_pkg::*;
(
  input  logic [WORD-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [WORD-1:0] branch_target_i,
  input  stall_pipeline_sig stall_i,
  output logic [WORD-1:0] next_pc_o
);

  // Priority select: branch, then stall, then sequential (wraps at 2^WORD).
  always_comb begin
    if (branch_taken_i) begin
      next_pc_o = branch_target_i;
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end else begin
      next_pc_o = pc_i + WORD'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit. With FETCH_BOOT_LOADER_EN defined, the unit starts
// in a program-load phase that streams half-words into instruction memory
// before running; without it, reset goes straight to fetching.
//
//   state      | meaning
//   FETCH_LOAD | accepting program beats, writing instruction memory
//   FETCH_RUN  | fetching; instruction_addr_o presents next_pc
module fetch_unit
  import general_defs_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_valid_i,
  input  logic [HALF_WORD-1:0] load_data_i,
  input  logic                 load_last_i,
  output logic                 load_ready_o,
  input  logic                 branch_taken_i,
  input  logic [WORD-1:0]      branch_target_i,
  input  stall_pipeline_sig    stall_pipeline_i,
  output logic                 program_mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 is_valid_o
);

  logic [WORD-1:0] pc;
  logic [WORD-1:0] next_pc;

  fetch_next_pc u_next_pc (
    .pc_i            (pc),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .stall_i         (stall_pipeline_i),
    .next_pc_o       (next_pc)
  );

`ifdef FETCH_BOOT_LOADER_EN

  fetch_state_t           state;
  logic [LOAD_ADDR_W-1:0] load_addr;
  logic                   load_fire;

  assign load_ready_o = (state == FETCH_LOAD);
  assign load_fire    = load_valid_i & load_ready_o;

  // Load/run FSM with load address, PC and valid flag; reset discards load progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= FETCH_LOAD;
      load_addr  <= '0;
      pc         <= RESET_VECTOR;
      is_valid_o <= 1'b0;
    end else begin
      case (state)
        FETCH_LOAD: begin
          is_valid_o <= 1'b0;
          if (load_fire) begin
            load_addr <= load_addr_inc(load_addr);
            if (load_last_i) begin
              state <= FETCH_RUN;
              pc    <= RESET_VECTOR;
            end
          end
        end
        FETCH_RUN: begin
          pc         <= next_pc;
          is_valid_o <= ~branch_taken_i;
        end
        default: begin
          state <= FETCH_LOAD;
        end
      endcase
    end
  end

  // Memory-side outputs: same-cycle write while loading, next_pc while running.
  always_comb begin
    if (state == FETCH_LOAD) begin
      program_mem_write_en_o = load_valid_i;
      instruction_o          = load_data_i;
      instruction_addr_o     = WORD'(load_addr);
    end else begin
      program_mem_write_en_o = 1'b0;
      instruction_o          = '0;
      instruction_addr_o     = next_pc;
    end
  end

`else

  // Load interface is inert in this build.
  logic unused_load;
  assign unused_load = ^{load_valid_i, load_last_i, load_data_i};

  assign load_ready_o           = 1'b0;
  assign program_mem_write_en_o = 1'b0;
  assign instruction_o          = '0;
  assign instruction_addr_o     = next_pc;

  // Always fetching: PC follows next_pc, slot invalid after reset or a branch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc         <= RESET_VECTOR;
      is_valid_o <= 1'b0;
    end else begin
      pc         <= next_pc;
      is_valid_o <= ~branch_taken_i;
    end
  end

`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Works for both builds: the boot-loader
// scenarios are compiled in only when FETCH_BOOT_LOADER_EN is defined.
module tb_fetch_unit;
  import general_defs_pkg::*;

`ifdef FETCH_BOOT_LOADER_EN
  localparam bit LOADER = 1'b1;
`else
  localparam bit LOADER = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        load_valid_i = 1'b0;
  logic [15:0] load_data_i = '0;
  logic        load_last_i = 1'b0;
  logic        load_ready_o;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        stall_pipeline_i = 1'b0;
  logic        program_mem_write_en_o;
  logic [15:0] instruction_o;
  logic [31:0] instruction_addr_o;
  logic        is_valid_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  fetch_unit dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .load_valid_i           (load_valid_i),
    .load_data_i            (load_data_i),
    .load_last_i            (load_last_i),
    .load_ready_o           (load_ready_o),
    .branch_taken_i         (branch_taken_i),
    .branch_target_i        (branch_target_i),
    .stall_pipeline_i       (stall_pipeline_i),
    .program_mem_write_en_o (program_mem_write_en_o),
    .instruction_o          (instruction_o),
    .instruction_addr_o     (instruction_addr_o),
    .is_valid_o             (is_valid_o)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: abstract machine state, not the RTL's encoding.
  bit          m_known = 1'b0;
  bit          m_loading = 1'b0;
  bit          m_valid = 1'b0;
  int          m_load_addr = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_next;

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk_i) begin
    if (branch_taken_i)        m_next = branch_target_i;
    else if (stall_pipeline_i) m_next = m_pc;
    else                       m_next = m_pc + 32'd1;

    if (m_known) begin
      if (m_loading) begin
        chk("load_ready", load_ready_o, 1);
        chk("load_we", program_mem_write_en_o, load_valid_i);
        chk("load_instr", instruction_o, load_data_i);
        chk("load_addr", instruction_addr_o, 64'(m_load_addr));
        chk("load_valid", is_valid_o, 0);
      end else begin
        chk("run_ready", load_ready_o, 0);
        chk("run_we", program_mem_write_en_o, 0);
        chk("run_instr", instruction_o, 0);
        chk("run_addr", instruction_addr_o, m_next);
        chk("run_valid", is_valid_o, m_valid);
      end
    end

    if (reset_i) begin
      m_known     = 1'b1;
      m_loading   = LOADER;
      m_load_addr = 0;
      m_pc        = '0;
      m_valid     = 1'b0;
    end else if (m_known) begin
      if (m_loading) begin
        if (load_valid_i) begin
          m_load_addr = (m_load_addr + 1) % PROG_MEM_DEPTH;
          if (load_last_i) begin
            m_loading = 1'b0;
            m_pc      = '0;
          end
        end
      end else begin
        m_pc    = m_next;
        m_valid = !branch_taken_i;
      end
    end
  end

  task automatic drive(input bit rst, input bit lv, input logic [15:0] ld, input bit ll,
                       input bit br, input logic [31:0] bt, input bit st);
    @(posedge clk_i);
    #1;
    reset_i          = rst;
    load_valid_i     = lv;
    load_data_i      = ld;
    load_last_i      = ll;
    branch_taken_i   = br;
    branch_target_i  = bt;
    stall_pipeline_i = st;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 16'h0, 0, 0, 32'h0, 0);
    drive(1, 0, 16'h0, 0, 0, 32'h0, 0);
  endtask

`ifdef FETCH_BOOT_LOADER_EN
  task automatic beat(input logic [15:0] d, input bit last);
    drive(0, 1, d, last, 0, 32'h0, 0);
  endtask
`endif

  initial begin
    do_reset();

`ifdef FETCH_BOOT_LOADER_EN
    // Three-beat program load, then run.
    beat(16'hA001, 0);
    @(negedge clk_i);
    chk("p3_addr0", instruction_addr_o, 0);
    chk("p3_we0", program_mem_write_en_o, 1);
    chk("p3_data0", instruction_o, 16'hA001);
    beat(16'hA002, 0);
    @(negedge clk_i);
    chk("p3_addr1", instruction_addr_o, 1);
    beat(16'hA003, 1);
    @(negedge clk_i);
    chk("p3_addr2", instruction_addr_o, 2);
    chk("p3_data2", instruction_o, 16'hA003);
    idle();
    @(negedge clk_i);
    chk("run_addr1", instruction_addr_o, 1);
    chk("run_valid1", is_valid_o, 0);
    chk("run_we_off", program_mem_write_en_o, 0);
    idle();
    @(negedge clk_i);
    chk("run_addr2", instruction_addr_o, 2);
    chk("run_valid2", is_valid_o, 1);
    idle();
    @(negedge clk_i);
    chk("run_addr3", instruction_addr_o, 3);
    chk("run_valid3", is_valid_o, 1);

    // Gap mid-load: no write, address held.
    do_reset();
    beat(16'h1111, 0);
    idle();
    @(negedge clk_i);
    chk("gap_we", program_mem_write_en_o, 0);
    chk("gap_addr", instruction_addr_o, 1);
    beat(16'h2222, 0);
    @(negedge clk_i);
    chk("after_gap_addr", instruction_addr_o, 1);
    chk("after_gap_we", program_mem_write_en_o, 1);

    // 513 beats without last: the 513th wraps to address 0.
    do_reset();
    for (int i = 0; i < 512; i++) beat(16'(i), 0);
    @(negedge clk_i);
    chk("beat512_addr", instruction_addr_o, 511);
    beat(16'hBEEF, 0);
    @(negedge clk_i);
    chk("beat513_addr", instruction_addr_o, 0);
    chk("beat513_we", program_mem_write_en_o, 1);

    // Reset after two beats discards progress.
    do_reset();
    beat(16'h0001, 0);
    beat(16'h0002, 0);
    drive(1, 0, 16'h0, 0, 0, 32'h0, 0);
    beat(16'h0003, 0);
    @(negedge clk_i);
    chk("rst_mid_ready", load_ready_o, 1);
    chk("rst_mid_addr", instruction_addr_o, 0);
    chk("rst_mid_valid", is_valid_o, 0);
    beat(16'h0004, 1);
`else
    // Straight to run after reset; write enable never asserted.
    idle();
    @(negedge clk_i);
    chk("run_addr1", instruction_addr_o, 1);
    chk("run_valid1", is_valid_o, 0);
    chk("run_we_off", program_mem_write_en_o, 0);
    chk("run_ready_off", load_ready_o, 0);
    idle();
    @(negedge clk_i);
    chk("run_addr2", instruction_addr_o, 2);
    chk("run_valid2", is_valid_o, 1);
    idle();
    @(negedge clk_i);
    chk("run_addr3", instruction_addr_o, 3);
    chk("run_valid3", is_valid_o, 1);
`endif

    // Reach pc=5 via branch, then stall two cycles.
    drive(0, 0, 16'h0, 0, 1, 32'd5, 0);
    @(negedge clk_i);
    chk("br5_addr", instruction_addr_o, 5);
    drive(0, 0, 16'h0, 0, 0, 32'h0, 1);
    @(negedge clk_i);
    chk("stall1_addr", instruction_addr_o, 5);
    chk("stall1_valid", is_valid_o, 0);
    drive(0, 0, 16'h0, 0, 0, 32'h0, 1);
    @(negedge clk_i);
    chk("stall2_addr", instruction_addr_o, 5);
    chk("stall2_valid", is_valid_o, 1);
    idle();
    @(negedge clk_i);
    chk("unstall_addr", instruction_addr_o, 6);

    // Branch overrides a simultaneous stall.
    drive(0, 0, 16'h0, 0, 1, 32'd5, 0);
    drive(0, 0, 16'h0, 0, 1, 32'h40, 1);
    @(negedge clk_i);
    chk("br_stall_addr", instruction_addr_o, 32'h40);
    idle();
    @(negedge clk_i);
    chk("post_br_valid", is_valid_o, 0);
    chk("post_br_addr", instruction_addr_o, 32'h41);
    idle();
    @(negedge clk_i);
    chk("post_br_valid2", is_valid_o, 1);

    // PC wraps at 2^WORD.
    drive(0, 0, 16'h0, 0, 1, 32'hFFFF_FFFF, 0);
    idle();
    @(negedge clk_i);
    chk("pc_wrap_addr", instruction_addr_o, 0);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 100) == 0,
            ($urandom % 2) == 0,
            16'($urandom),
            ($urandom % 16) == 0,
            ($urandom % 8) == 0,
            (($urandom % 4) == 0) ? 32'hFFFF_FFFF - 32'($urandom % 3) : 32'($urandom),
            ($urandom % 4) == 0);
    end
    idle();
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
